// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war input front end.
package tug_pkg;

    // Debounce/one-shot state per button channel.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } btn_state_t;

    // Flops in the metastability synchronizer for each raw button.
    localparam int unsigned SYNC_STAGES = 2;

endpackage : tug_pkg

// File: rtl/btn_oneshot.sv
// One button channel: synchronizer, debounce counter and one-shot FSM.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high
//   key_n  - raw active-low button, asynchronous to clk
//   pulse  - one-cycle combinational pulse when a press is accepted;
//            the top level registers it
module btn_oneshot
    import tug_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_s;
    btn_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Synchronizer; resets to the released (high) level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
        end
    end

    assign key_s = ~sync_q[SYNC_STAGES-1];

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and pulse; the counter stops at CNT_MAX and never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse   = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_s) begin
                    state_d = PRESS_DB;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_DB: begin
                if (!key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    state_d = HELD;
                    cnt_d   = '0;
                    pulse   = 1'b1;
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_d = RELEASE_DB;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_DB: begin
                if (key_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule : btn_oneshot

// File: rtl/tug_input_conditioner.sv
// Turns the two raw player buttons into registered single-cycle move pulses.
// Ports:
//   clk      - system clock
//   reset    - synchronous, active-high
//   key_l_n  - raw left button, active-low, asynchronous
//   key_r_n  - raw right button, active-low, asynchronous
//   freeze   - high while the game is over; blocks L/R but not the FSMs
//   L, R     - one-cycle pulse per accepted left / right press
module tug_input_conditioner
    import tug_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic key_l_n,
    input  logic key_r_n,
    input  logic freeze,
    output logic L,
    output logic R
);

    logic pulse_l;
    logic pulse_r;

    btn_oneshot #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_left (
        .clk  (clk),
        .reset(reset),
        .key_n(key_l_n),
        .pulse(pulse_l)
    );

    btn_oneshot #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_right (
        .clk  (clk),
        .reset(reset),
        .key_n(key_r_n),
        .pulse(pulse_r)
    );

    // Output gate: a press consumed during freeze is simply lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            L <= 1'b0;
            R <= 1'b0;
        end else begin
            L <= pulse_l & ~freeze;
            R <= pulse_r & ~freeze;
        end
    end

endmodule : tug_input_conditioner

// File: tb/tb_tug_input_conditioner.sv
// Bench for tug_input_conditioner: each accepted press pushes the expected
// pulse cycle into a per-channel queue; a monitor pops and compares on pulses.
module tb_tug_input_conditioner;
    import tug_pkg::*;

    localparam int unsigned DB      = 4;
    localparam int unsigned LATENCY = DB + 3;  // drive-time cycle to sampled pulse

    logic clk = 1'b0;
    logic reset;
    logic key_l_n;
    logic key_r_n;
    logic freeze;
    logic L;
    logic R;

    int unsigned cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int unsigned exp_l[$];
    int unsigned exp_r[$];

    tug_input_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk    (clk),
        .reset  (reset),
        .key_l_n(key_l_n),
        .key_r_n(key_r_n),
        .freeze (freeze),
        .L      (L),
        .R      (R)
    );

    always #25 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every observed pulse must match the queue head.
    always @(negedge clk) begin
        if (L === 1'b1) begin
            if (exp_l.size() == 0) check("L_unexpected", 32'(cyc), 32'(0));
            else check("L_pulse_cycle", 32'(cyc), 32'(exp_l.pop_front()));
        end
        if (R === 1'b1) begin
            if (exp_r.size() == 0) check("R_unexpected", 32'(cyc), 32'(0));
            else check("R_pulse_cycle", 32'(cyc), 32'(exp_r.pop_front()));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        check({tag, "_L_pending"}, 32'(exp_l.size()), 32'(0));
        check({tag, "_R_pending"}, 32'(exp_r.size()), 32'(0));
        exp_l.delete();
        exp_r.delete();
    endtask

    initial begin
        reset   = 1'b1;
        key_l_n = 1'b1;
        key_r_n = 1'b1;
        freeze  = 1'b0;

        // 1: reset state
        step(2);
        check("rst_L", 32'(L), 32'(0));
        check("rst_R", 32'(R), 32'(0));
        check("rst_state_l", 32'(dut.u_left.state_q), 32'(IDLE));
        check("rst_state_r", 32'(dut.u_right.state_q), 32'(IDLE));
        reset = 1'b0;
        step(3);

        // 2: single left press held 12 cycles
        key_l_n = 1'b0;
        exp_l.push_back(cyc + LATENCY);
        step(12);
        key_l_n = 1'b1;
        step(12);
        drain("t2");

        // 3: short right glitches are rejected
        for (int i = 0; i < 3; i++) begin
            key_r_n = 1'b0;
            step(3);
            key_r_n = 1'b1;
            step(3);
        end
        step(8);
        drain("t3");

        // 4: simultaneous press, then a bounce during release
        key_l_n = 1'b0;
        key_r_n = 1'b0;
        exp_l.push_back(cyc + LATENCY);
        exp_r.push_back(cyc + LATENCY);
        step(12);
        key_l_n = 1'b1;
        key_r_n = 1'b1;
        step(2);
        key_l_n = 1'b0;
        key_r_n = 1'b0;
        step(2);
        key_l_n = 1'b1;
        key_r_n = 1'b1;
        step(14);
        drain("t4");

        // 5: press during freeze is consumed; a later press fires
        freeze  = 1'b1;
        key_l_n = 1'b0;
        step(10);
        freeze = 1'b0;
        step(5);
        key_l_n = 1'b1;
        step(10);
        key_l_n = 1'b0;
        exp_l.push_back(cyc + LATENCY);
        step(10);
        key_l_n = 1'b1;
        step(10);
        drain("t5");

        // 6: reset mid-debounce restarts the debounce
        key_l_n = 1'b0;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        exp_l.push_back(cyc + LATENCY);
        step(12);
        key_l_n = 1'b1;
        step(12);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_tug_input_conditioner
